// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment scan display.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package display_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t HexSeg [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic int unsigned dwell_cycles(input int unsigned clk_hz,
                                               input int unsigned scan_hz);
    return clk_hz / scan_hz;
  endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment lookup.
module hex_to_seg
  import display_pkg::*;
(
  input  logic [3:0] nib_i,
  output seg_t       seg_o
);

  assign seg_o = HexSeg[nib_i];

endmodule

// File: rtl/scan_display_ctrl.sv
// Time-multiplexed seven-segment scan controller with tear-free shadow/active
// display buffers swapped at frame boundaries.
module scan_display_ctrl
  import display_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned SCAN_HZ = 1000,
  parameter int unsigned GUARD   = 16,
  parameter int unsigned NDIG    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data,
  input  logic [7:0]  dp,
  input  logic [7:0]  blank,
  input  logic        load,
  input  logic        enb,
  output logic [2:0]  digit_sel,
  output logic        an_en,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic        scan_tick,
  output logic        frame_done
);

  localparam int unsigned Dwell  = dwell_cycles(CLK_HZ, SCAN_HZ);
  localparam int unsigned PrescW = $clog2(Dwell);
  localparam logic [PrescW-1:0] PrescLast = PrescW'(Dwell - 1);
  localparam logic [PrescW-1:0] PrescGuard = PrescW'(GUARD);
  localparam logic [2:0] DigitLast = 3'(NDIG - 1);

  logic [PrescW-1:0] presc_q, presc_d;
  logic [2:0]        digit_q, digit_d;
  logic [31:0]       sh_data_q, sh_data_d, act_data_q, act_data_d;
  logic [7:0]        sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
  logic [7:0]        sh_blank_q, sh_blank_d, act_blank_q, act_blank_d;
  logic              pending_q, pending_d;
  logic              an_en_q, an_en_d;
  logic              dp_n_q, dp_n_d;
  logic              tick_q, tick_d;
  logic              fdone_q, fdone_d;
  seg_t              seg_q, seg_d, seg_lut;
  logic [3:0]        nib;
  logic              step, wrap;

  always_comb begin
    step = (presc_q == PrescLast);
    wrap = step && (digit_q == DigitLast);

    presc_d = step ? '0 : presc_q + 1'b1;
    digit_d = digit_q;
    if (step) digit_d = wrap ? 3'd0 : digit_q + 3'd1;

    // The swap uses the shadow as it stood before any load in this same cycle.
    act_data_d  = act_data_q;
    act_dp_d    = act_dp_q;
    act_blank_d = act_blank_q;
    if (wrap && pending_q) begin
      act_data_d  = sh_data_q;
      act_dp_d    = sh_dp_q;
      act_blank_d = sh_blank_q;
    end

    sh_data_d  = load ? data  : sh_data_q;
    sh_dp_d    = load ? dp    : sh_dp_q;
    sh_blank_d = load ? blank : sh_blank_q;
    pending_d  = load | (pending_q & ~wrap);

    nib     = act_data_d[{digit_d, 2'b00} +: 4];
    an_en_d = enb & (presc_d >= PrescGuard) & ~act_blank_d[digit_d];
    seg_d   = an_en_d ? seg_lut : 7'h7F;
    dp_n_d  = an_en_d ? ~act_dp_d[digit_d] : 1'b1;
    tick_d  = (presc_d == PrescLast);
    fdone_d = tick_d && (digit_d == DigitLast);
  end

  hex_to_seg u_hex_to_seg (
    .nib_i (nib),
    .seg_o (seg_lut)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q     <= '0;
      digit_q     <= '0;
      sh_data_q   <= '0;
      sh_dp_q     <= '0;
      sh_blank_q  <= 8'hFF;
      act_data_q  <= '0;
      act_dp_q    <= '0;
      act_blank_q <= 8'hFF;
      pending_q   <= 1'b0;
      an_en_q     <= 1'b0;
      seg_q       <= 7'h7F;
      dp_n_q      <= 1'b1;
      tick_q      <= 1'b0;
      fdone_q     <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      digit_q     <= digit_d;
      sh_data_q   <= sh_data_d;
      sh_dp_q     <= sh_dp_d;
      sh_blank_q  <= sh_blank_d;
      act_data_q  <= act_data_d;
      act_dp_q    <= act_dp_d;
      act_blank_q <= act_blank_d;
      pending_q   <= pending_d;
      an_en_q     <= an_en_d;
      seg_q       <= seg_d;
      dp_n_q      <= dp_n_d;
      tick_q      <= tick_d;
      fdone_q     <= fdone_d;
    end
  end

  assign digit_sel  = digit_q;
  assign an_en      = an_en_q;
  assign seg_n      = seg_q;
  assign dp_n       = dp_n_q;
  assign scan_tick  = tick_q;
  assign frame_done = fdone_q;

endmodule
